// File: rtl/alu_md_unit.sv
// Execute-stage ALU with registered results, arithmetic flags, shifts and an
// iterative unsigned multiply/divide engine behind a valid/ready handshake.
module alu_md_unit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    input  logic [WIDTH-1:0] Bus_A_ALU,
    input  logic [WIDTH-1:0] Bus_B_ALU,
    input  logic [3:0]       ALU_control,
    output logic             out_valid,
    output logic [WIDTH-1:0] ALU_out,
    output logic [WIDTH-1:0] ALU_hi,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam int unsigned SW = $clog2(WIDTH);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned W1 = WIDTH + 1;

    localparam logic [3:0] OpAnd  = 4'd0;
    localparam logic [3:0] OpOr   = 4'd1;
    localparam logic [3:0] OpAdd  = 4'd2;
    localparam logic [3:0] OpSub  = 4'd3;
    localparam logic [3:0] OpSlt  = 4'd4;
    localparam logic [3:0] OpXor  = 4'd5;
    localparam logic [3:0] OpNor  = 4'd6;
    localparam logic [3:0] OpSll  = 4'd7;
    localparam logic [3:0] OpSrl  = 4'd8;
    localparam logic [3:0] OpSra  = 4'd9;
    localparam logic [3:0] OpMulu = 4'd10;
    localparam logic [3:0] OpDivu = 4'd11;

    typedef enum logic {StIdle, StBusy} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             dbz_q, dbz_d;
    logic             valid_q, valid_d;

    logic             accept;
    logic [SW-1:0]    shamt;
    logic [WIDTH:0]   sum_add, sum_sub;
    logic [WIDTH-1:0] sc_res;
    logic             sc_carry, sc_ovf;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] step_acc, step_lo;

    assign in_ready = (state_q == StIdle) & ~flush;
    assign accept   = in_valid & in_ready;
    assign shamt    = Bus_B_ALU[SW-1:0];
    assign sum_add  = {1'b0, Bus_A_ALU} + {1'b0, Bus_B_ALU};
    assign sum_sub  = {1'b0, Bus_A_ALU} + {1'b0, ~Bus_B_ALU} + W1'(1);

    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        case (ALU_control)
            OpAnd: sc_res = Bus_A_ALU & Bus_B_ALU;
            OpOr:  sc_res = Bus_A_ALU | Bus_B_ALU;
            OpAdd: begin
                sc_res   = sum_add[WIDTH-1:0];
                sc_carry = sum_add[WIDTH];
                sc_ovf   = (Bus_A_ALU[WIDTH-1] == Bus_B_ALU[WIDTH-1]) &&
                           (sum_add[WIDTH-1] != Bus_A_ALU[WIDTH-1]);
            end
            OpSub: begin
                sc_res   = sum_sub[WIDTH-1:0];
                sc_carry = sum_sub[WIDTH];
                sc_ovf   = (Bus_A_ALU[WIDTH-1] != Bus_B_ALU[WIDTH-1]) &&
                           (sum_sub[WIDTH-1] != Bus_A_ALU[WIDTH-1]);
            end
            OpSlt: sc_res = {{(WIDTH-1){1'b0}}, ($signed(Bus_A_ALU) < $signed(Bus_B_ALU))};
            OpXor: sc_res = Bus_A_ALU ^ Bus_B_ALU;
            OpNor: sc_res = ~(Bus_A_ALU | Bus_B_ALU);
            OpSll: sc_res = Bus_A_ALU << shamt;
            OpSrl: sc_res = Bus_A_ALU >> shamt;
            OpSra: sc_res = $signed(Bus_A_ALU) >>> shamt;
            default: sc_res = '0;
        endcase
    end

    // One iteration: shift-add for MULU, restoring subtract for DIVU.
    // {acc_q, lo_q} is the product register or the remainder/quotient pair.
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q, lo_q[WIDTH-1]};
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        if (is_div_q) begin
            if (div_shift >= {1'b0, opnd_q}) begin
                step_acc = div_diff;
                step_lo  = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_acc = div_shift[WIDTH-1:0];
                step_lo  = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_acc = mul_sum[WIDTH:1];
            step_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        out_d    = out_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        dbz_d    = dbz_q;
        valid_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (ALU_control == OpMulu || ALU_control == OpDivu) begin
                        state_d  = StBusy;
                        cnt_d    = CW'(WIDTH);
                        is_div_d = (ALU_control == OpDivu);
                        opnd_d   = (ALU_control == OpDivu) ? Bus_B_ALU : Bus_A_ALU;
                        lo_d     = (ALU_control == OpDivu) ? Bus_A_ALU : Bus_B_ALU;
                        acc_d    = '0;
                    end else begin
                        out_d   = sc_res;
                        hi_d    = '0;
                        zero_d  = (sc_res == '0);
                        carry_d = sc_carry;
                        ovf_d   = sc_ovf;
                        dbz_d   = 1'b0;
                        valid_d = 1'b1;
                    end
                end
            end
            StBusy: begin
                if (flush) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    acc_d = step_acc;
                    lo_d  = step_lo;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        // Division by zero falls out naturally: quotient all ones, remainder A.
                        state_d = StIdle;
                        out_d   = step_lo;
                        hi_d    = step_acc;
                        zero_d  = (step_lo == '0);
                        carry_d = 1'b0;
                        ovf_d   = 1'b0;
                        dbz_d   = is_div_q && (opnd_q == '0);
                        valid_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            out_q    <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            out_q    <= out_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            dbz_q    <= dbz_d;
            valid_q  <= valid_d;
        end
    end

    assign out_valid   = valid_q;
    assign ALU_out     = out_q;
    assign ALU_hi      = hi_q;
    assign zero        = zero_q;
    assign carry       = carry_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_md_unit.sv
// Scoreboard bench for alu_md_unit: driver pushes expected results, a negedge
// monitor pops and compares on every out_valid.
module tb_alu_md_unit;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] out;
        logic         z;
        logic         c;
        logic         ov;
        logic         dz;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         flush;
    logic [W-1:0] Bus_A_ALU;
    logic [W-1:0] Bus_B_ALU;
    logic [3:0]   ALU_control;
    logic         out_valid;
    logic [W-1:0] ALU_out;
    logic [W-1:0] ALU_hi;
    logic         zero;
    logic         carry;
    logic         overflow;
    logic         div_by_zero;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    alu_md_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .Bus_A_ALU  (Bus_A_ALU),
        .Bus_B_ALU  (Bus_B_ALU),
        .ALU_control(ALU_control),
        .out_valid  (out_valid),
        .ALU_out    (ALU_out),
        .ALU_hi     (ALU_hi),
        .zero       (zero),
        .carry      (carry),
        .overflow   (overflow),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] o, input logic [W-1:0] h,
                                input logic z, input logic c, input logic ov, input logic dz);
        exp_t e;
        e.out = o; e.hi = h; e.z = z; e.c = c; e.ov = ov; e.dz = dz;
        return e;
    endfunction

    // Reference model from the opcode definitions using plain integer arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t            e;
        longint          sa, sb, r, smax, smin;
        longint unsigned ua, ub, p;
        int              sh;
        e    = '0;
        sa   = $signed(a);
        sb   = $signed(b);
        ua   = a;
        ub   = b;
        sh   = int'(ub % W);
        smax = (longint'(1) <<< (W - 1)) - 1;
        smin = -(longint'(1) <<< (W - 1));
        case (op)
            4'd0: e.out = a & b;
            4'd1: e.out = a | b;
            4'd2: begin
                e.out = W'(ua + ub);
                e.c   = (ua + ub) >= (64'd1 << W);
                r     = sa + sb;
                e.ov  = (r > smax) || (r < smin);
            end
            4'd3: begin
                e.out = W'(ua - ub);
                e.c   = (ua >= ub);
                r     = sa - sb;
                e.ov  = (r > smax) || (r < smin);
            end
            4'd4: e.out = (sa < sb) ? W'(1) : W'(0);
            4'd5: e.out = a ^ b;
            4'd6: e.out = ~(a | b);
            4'd7: e.out = W'(ua << sh);
            4'd8: e.out = W'(ua >> sh);
            4'd9: e.out = W'(sa >>> sh);
            4'd10: begin
                p    = ua * ub;
                e.out = W'(p);
                e.hi  = W'(p >> W);
            end
            4'd11: begin
                if (ub == 0) begin
                    e.out = '1;
                    e.hi  = a;
                    e.dz  = 1'b1;
                end else begin
                    e.out = W'(ua / ub);
                    e.hi  = W'(ua % ub);
                end
            end
            default: e.out = '0;
        endcase
        e.z = (e.out == '0);
        return e;
    endfunction

    // mode 0: push model result, 1: push ex, 2: push nothing (op will be aborted)
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int mode, input exp_t ex);
        int t;
        @(negedge clk);
        in_valid    = 1'b1;
        ALU_control = op;
        Bus_A_ALU   = a;
        Bus_B_ALU   = b;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, t);
        end else if (mode == 0) begin
            sb_q.push_back(model(op, a, b));
        end else if (mode == 1) begin
            sb_q.push_back(ex);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic rand_opnd(output logic [W-1:0] v);
        case ($urandom_range(0, 5))
            0: v = '0;
            1: v = '1;
            2: v = {1'b1, {(W-1){1'b0}}};
            3: v = {1'b0, {(W-1){1'b1}}};
            default: v = W'($urandom);
        endcase
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out_valid: ALU_out=%h ALU_hi=%h, no result expected",
                         ALU_out, ALU_hi);
            end else begin
                mon_e = sb_q.pop_front();
                check("result{hi,out,z,c,ov,dz}",
                      64'({ALU_hi, ALU_out, zero, carry, overflow, div_by_zero}), 64'(mon_e));
            end
        end
    end

    initial begin
        exp_t         t1[10];
        int           n;
        int           busy_bad;
        logic [3:0]   op;
        logic [W-1:0] a, b;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        flush       = 1'b0;
        Bus_A_ALU   = '0;
        Bus_B_ALU   = '0;
        ALU_control = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 64'({ALU_hi, ALU_out, zero, carry, overflow, div_by_zero,
                                    out_valid}), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        // Single-cycle ops back to back on A=C000, B=FFFF.
        t1[0] = mk(16'hC000, 16'h0, 0, 0, 0, 0);
        t1[1] = mk(16'hFFFF, 16'h0, 0, 0, 0, 0);
        t1[2] = mk(16'hBFFF, 16'h0, 0, 1, 0, 0);
        t1[3] = mk(16'hC001, 16'h0, 0, 0, 0, 0);
        t1[4] = mk(16'h0001, 16'h0, 0, 0, 0, 0);
        t1[5] = mk(16'h3FFF, 16'h0, 0, 0, 0, 0);
        t1[6] = mk(16'h0000, 16'h0, 1, 0, 0, 0);
        t1[7] = mk(16'h0000, 16'h0, 1, 0, 0, 0);
        t1[8] = mk(16'h0001, 16'h0, 0, 0, 0, 0);
        t1[9] = mk(16'hFFFF, 16'h0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) issue(4'(i), 16'hC000, 16'hFFFF, 1, t1[i]);
        issue(4'd2, 16'h7FFF, 16'h0001, 1, mk(16'h8000, 16'h0, 0, 0, 1, 0));
        issue(4'd3, 16'h0005, 16'h0005, 1, mk(16'h0000, 16'h0, 1, 1, 0, 0));
        issue(4'd13, 16'h1234, 16'h5678, 1, mk(16'h0000, 16'h0, 1, 0, 0, 0));
        idle();

        // MULU latency: WIDTH cycles with in_ready low, then the result.
        issue(4'd10, 16'hFFFF, 16'hFFFF, 1, mk(16'h0001, 16'hFFFE, 0, 0, 0, 0));
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        busy_bad = 0;
        while (!out_valid && n < 100) begin
            if (in_ready) busy_bad++;
            n++;
            @(negedge clk);
        end
        check("mulu_latency", 64'(n), 64'(W));
        check("busy_in_ready_low", 64'(busy_bad), 64'd0);
        check("in_ready_with_out_valid", 64'(in_ready), 64'd1);

        issue(4'd11, 16'h0064, 16'h0007, 1, mk(16'h000E, 16'h0002, 0, 0, 0, 0));
        issue(4'd11, 16'h1234, 16'h0000, 1, mk(16'hFFFF, 16'h1234, 0, 0, 0, 1));
        issue(4'd2, 16'h0001, 16'h0002, 1, mk(16'h0003, 16'h0, 0, 0, 0, 0));
        idle();

        // Flush mid-MULU: no result, back to idle, next op normal.
        issue(4'd10, 16'h0003, 16'h0005, 2, '0);
        idle();
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_no_valid", 64'(out_valid), 64'd0);
        repeat (W + 2) @(negedge clk);
        issue(4'd2, 16'h0001, 16'h0001, 1, mk(16'h0002, 16'h0, 0, 0, 0, 0));
        idle();

        // Flush in idle blocks the accept.
        flush       = 1'b1;
        in_valid    = 1'b1;
        ALU_control = 4'd2;
        Bus_A_ALU   = 16'h0005;
        Bus_B_ALU   = 16'h0006;
        #1;
        check("flush_gates_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("flush_blocks_accept", 64'(out_valid), 64'd0);
        in_valid = 1'b0;
        flush    = 1'b0;

        // Async reset in the middle of a DIVU.
        issue(4'd2, 16'h0003, 16'h0004, 0, '0);
        issue(4'd11, 16'h0064, 16'h0007, 2, '0);
        idle();
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 64'({ALU_hi, ALU_out, zero, carry, overflow, div_by_zero,
                                          out_valid}), 64'd0);
        check("async_reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        issue(4'd2, 16'h0001, 16'h0001, 0, '0);

        for (int i = 0; i < 400; i++) begin
            op = 4'($urandom_range(0, 15));
            rand_opnd(a);
            rand_opnd(b);
            issue(op, a, b, 0, '0);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();

        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
